// File: rtl/id_stage.sv
// id_stage: registered instruction-decode stage for the 16-bit CPU.
// Decodes one opcode per cycle, holds it behind valid/ready, and bubbles on load-use hazards.
module id_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  if_valid_i,
    input  logic [15:0]           if_op_i,
    input  logic [DATA_W-1:0]     if_pc_i,
    output logic                  if_ready_o,
    input  logic                  flush_i,
    input  logic                  ex_ready_i,
    output logic                  id_valid_o,
    output logic [DATA_W-1:0]     id_pc_o,
    output logic                  read_en1_o,
    output logic                  read_en2_o,
    output logic [REG_ADDR_W-1:0] read_addr1_o,
    output logic [REG_ADDR_W-1:0] read_addr2_o,
    output logic                  reg_write_o,
    output logic [REG_ADDR_W-1:0] reg_addr_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [DATA_W-1:0]     imm_o,
    output logic [3:0]            alu_op_o,
    output logic [2:0]            br_type_o,
    output logic                  illegal_o
);
    // state | meaning
    // EMPTY | no instruction held, id_valid_o = 0
    // FULL  | decoded instruction held until execute takes it
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_AND     = 4'd2;
    localparam logic [3:0] ALU_OR      = 4'd3;
    localparam logic [3:0] ALU_SLL     = 4'd4;
    localparam logic [3:0] ALU_SRL     = 4'd5;
    localparam logic [3:0] ALU_SRA     = 4'd6;
    localparam logic [3:0] ALU_SRAV    = 4'd7;
    localparam logic [3:0] ALU_CMP     = 4'd8;
    localparam logic [3:0] ALU_PASS_A  = 4'd9;
    localparam logic [3:0] ALU_PASS_B  = 4'd10;
    localparam logic [3:0] ALU_PASS_PC = 4'd11;

    localparam logic [2:0] BR_B     = 3'd1;
    localparam logic [2:0] BR_BEQZ  = 3'd2;
    localparam logic [2:0] BR_BNEZ  = 3'd3;
    localparam logic [2:0] BR_BTEQZ = 3'd4;
    localparam logic [2:0] BR_JR    = 3'd5;

    localparam logic [REG_ADDR_W-1:0] REG_SP = REG_ADDR_W'(8);
    localparam logic [REG_ADDR_W-1:0] REG_T  = REG_ADDR_W'(9);
    localparam logic [REG_ADDR_W-1:0] REG_IH = REG_ADDR_W'(10);
    localparam logic [REG_ADDR_W-1:0] REG_RA = REG_ADDR_W'(11);

    typedef struct packed {
        logic                  read_en1;
        logic                  read_en2;
        logic [REG_ADDR_W-1:0] read_addr1;
        logic [REG_ADDR_W-1:0] read_addr2;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] reg_addr;
        logic                  mem_read;
        logic                  mem_write;
        logic [DATA_W-1:0]     imm;
        logic [3:0]            alu_op;
        logic [2:0]            br_type;
        logic                  illegal;
    } dec_t;

    state_t              state_q, state_d;
    dec_t                dec, dec_q;
    logic [DATA_W-1:0]   pc_q;
    logic                ill, hazard, if_ready, load;
    logic [REG_ADDR_W-1:0] rx, ry, rz;
    logic [DATA_W-1:0]   se4, se5, se8, se11, ze8, shamt;

    assign rx    = REG_ADDR_W'(if_op_i[10:8]);
    assign ry    = REG_ADDR_W'(if_op_i[7:5]);
    assign rz    = REG_ADDR_W'(if_op_i[4:2]);
    assign se4   = {{(DATA_W-4){if_op_i[3]}}, if_op_i[3:0]};
    assign se5   = {{(DATA_W-5){if_op_i[4]}}, if_op_i[4:0]};
    assign se8   = {{(DATA_W-8){if_op_i[7]}}, if_op_i[7:0]};
    assign se11  = {{(DATA_W-11){if_op_i[10]}}, if_op_i[10:0]};
    assign ze8   = {{(DATA_W-8){1'b0}}, if_op_i[7:0]};
    // A shift field of zero encodes a shift by 8.
    assign shamt = (if_op_i[4:2] == 3'd0) ? DATA_W'(8) : DATA_W'(if_op_i[4:2]);

    always_comb begin
        dec = '0;
        ill = 1'b0;
        case (if_op_i[15:11])
            5'b00001: ill = (if_op_i[10:0] != 11'd0);
            5'b00010: begin dec.imm = se11; dec.br_type = BR_B; end
            5'b00100: begin
                dec.read_en1 = 1'b1; dec.read_addr1 = rx; dec.imm = se8; dec.br_type = BR_BEQZ;
            end
            5'b00101: begin
                dec.read_en1 = 1'b1; dec.read_addr1 = rx; dec.imm = se8; dec.br_type = BR_BNEZ;
            end
            5'b00110: begin
                dec.read_en2 = 1'b1; dec.read_addr2 = ry;
                dec.reg_write = 1'b1; dec.reg_addr = rx; dec.imm = shamt;
                case (if_op_i[1:0])
                    2'b00:   dec.alu_op = ALU_SLL;
                    2'b10:   dec.alu_op = ALU_SRL;
                    2'b11:   dec.alu_op = ALU_SRA;
                    default: ill = 1'b1;
                endcase
            end
            5'b01000: begin
                dec.read_en1 = 1'b1; dec.read_addr1 = rx;
                dec.reg_write = 1'b1; dec.reg_addr = ry; dec.imm = se4;
                ill = if_op_i[4];
            end
            5'b01001: begin
                dec.read_en1 = 1'b1; dec.read_addr1 = rx;
                dec.reg_write = 1'b1; dec.reg_addr = rx; dec.imm = se8;
            end
            5'b01100: begin
                case (if_op_i[10:8])
                    3'b000: begin
                        dec.read_en1 = 1'b1; dec.read_addr1 = REG_T;
                        dec.imm = se8; dec.br_type = BR_BTEQZ;
                    end
                    3'b011: begin
                        dec.read_en1 = 1'b1; dec.read_addr1 = REG_SP;
                        dec.reg_write = 1'b1; dec.reg_addr = REG_SP; dec.imm = se8;
                    end
                    3'b100: begin
                        dec.read_en1 = 1'b1; dec.read_addr1 = rx;
                        dec.reg_write = 1'b1; dec.reg_addr = REG_SP; dec.alu_op = ALU_PASS_A;
                        ill = (if_op_i[4:0] != 5'd0);
                    end
                    default: ill = 1'b1;
                endcase
            end
            5'b01101: begin
                dec.reg_write = 1'b1; dec.reg_addr = rx; dec.imm = ze8; dec.alu_op = ALU_PASS_B;
            end
            5'b01111: begin
                dec.read_en2 = 1'b1; dec.read_addr2 = ry;
                dec.reg_write = 1'b1; dec.reg_addr = rx; dec.alu_op = ALU_PASS_B;
                ill = (if_op_i[4:0] != 5'd0);
            end
            5'b10010: begin
                dec.read_en1 = 1'b1; dec.read_addr1 = REG_SP;
                dec.reg_write = 1'b1; dec.reg_addr = rx; dec.mem_read = 1'b1; dec.imm = se8;
            end
            5'b10011: begin
                dec.read_en1 = 1'b1; dec.read_addr1 = rx;
                dec.reg_write = 1'b1; dec.reg_addr = ry; dec.mem_read = 1'b1; dec.imm = se5;
            end
            5'b11010: begin
                dec.read_en1 = 1'b1; dec.read_addr1 = REG_SP;
                dec.read_en2 = 1'b1; dec.read_addr2 = rx; dec.mem_write = 1'b1; dec.imm = se8;
            end
            5'b11011: begin
                dec.read_en1 = 1'b1; dec.read_addr1 = rx;
                dec.read_en2 = 1'b1; dec.read_addr2 = ry; dec.mem_write = 1'b1; dec.imm = se5;
            end
            5'b11100: begin
                dec.read_en1 = 1'b1; dec.read_addr1 = rx;
                dec.read_en2 = 1'b1; dec.read_addr2 = ry;
                dec.reg_write = 1'b1; dec.reg_addr = rz;
                case (if_op_i[1:0])
                    2'b01:   dec.alu_op = ALU_ADD;
                    2'b11:   dec.alu_op = ALU_SUB;
                    default: ill = 1'b1;
                endcase
            end
            5'b11101: begin
                dec.read_en1 = 1'b1; dec.read_addr1 = rx;
                dec.read_en2 = 1'b1; dec.read_addr2 = ry;
                dec.reg_write = 1'b1; dec.reg_addr = rx;
                case (if_op_i[4:0])
                    5'b01100: dec.alu_op = ALU_AND;
                    5'b01101: dec.alu_op = ALU_OR;
                    5'b01010: begin dec.alu_op = ALU_CMP; dec.reg_addr = REG_T; end
                    5'b00111: begin dec.alu_op = ALU_SRAV; dec.reg_addr = ry; end
                    5'b00000: begin
                        // Jump / PC group: overrides the two-source defaults above.
                        dec.read_en2 = 1'b0; dec.read_addr2 = '0;
                        dec.reg_write = 1'b0; dec.reg_addr = '0;
                        case (if_op_i[7:5])
                            3'b000: begin dec.alu_op = ALU_PASS_A; dec.br_type = BR_JR; end
                            3'b110: begin
                                dec.reg_write = 1'b1; dec.reg_addr = REG_RA;
                                dec.alu_op = ALU_PASS_PC; dec.br_type = BR_JR;
                            end
                            3'b010: begin
                                dec.read_en1 = 1'b0; dec.read_addr1 = '0;
                                dec.reg_write = 1'b1; dec.reg_addr = rx; dec.alu_op = ALU_PASS_PC;
                            end
                            3'b001: begin
                                dec.read_addr1 = REG_RA; dec.alu_op = ALU_PASS_A; dec.br_type = BR_JR;
                                ill = (if_op_i[10:8] != 3'd0);
                            end
                            default: ill = 1'b1;
                        endcase
                    end
                    default: ill = 1'b1;
                endcase
            end
            5'b11110: begin
                dec.read_en1 = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALU_PASS_A;
                case (if_op_i[7:0])
                    8'h00:   begin dec.read_addr1 = REG_IH; dec.reg_addr = rx; end
                    8'h01:   begin dec.read_addr1 = rx; dec.reg_addr = REG_IH; end
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    // Load-use: the held load's destination is read by the incoming opcode.
    assign hazard = (state_q == FULL) & dec_q.mem_read & dec_q.reg_write &
                    ((dec.read_en1 & (dec.read_addr1 == dec_q.reg_addr)) |
                     (dec.read_en2 & (dec.read_addr2 == dec_q.reg_addr)));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= EMPTY;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        if_ready = ~hazard & ((state_q == EMPTY) | ex_ready_i);
        case (state_q)
            EMPTY: begin
                if (!flush_i && if_valid_i && if_ready) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (flush_i)                       state_d = EMPTY;
                else if (if_valid_i && if_ready)   load    = 1'b1;
                else if (ex_ready_i)               state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dec_q <= '0;
            pc_q  <= '0;
        end else if (load) begin
            dec_q <= dec;
            pc_q  <= if_pc_i;
        end
    end

    assign if_ready_o   = if_ready;
    assign id_valid_o   = (state_q == FULL);
    assign id_pc_o      = pc_q;
    assign read_en1_o   = dec_q.read_en1;
    assign read_en2_o   = dec_q.read_en2;
    assign read_addr1_o = dec_q.read_addr1;
    assign read_addr2_o = dec_q.read_addr2;
    assign reg_write_o  = dec_q.reg_write;
    assign reg_addr_o   = dec_q.reg_addr;
    assign mem_read_o   = dec_q.mem_read;
    assign mem_write_o  = dec_q.mem_write;
    assign imm_o        = dec_q.imm;
    assign alu_op_o     = dec_q.alu_op;
    assign br_type_o    = dec_q.br_type;
    assign illegal_o    = dec_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed plan steps then randomized traffic against a mnemonic-table reference model.
module tb_id_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, if_valid, flush, ex_ready;
    logic [15:0] if_op, if_pc;
    logic        if_ready, id_valid, read_en1, read_en2, reg_write, mem_read, mem_write, illegal;
    logic [15:0] id_pc, imm;
    logic [3:0]  read_addr1, read_addr2, reg_addr, alu_op;
    logic [2:0]  br_type;

    id_stage #(.DATA_W(16), .REG_ADDR_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .if_valid_i(if_valid), .if_op_i(if_op), .if_pc_i(if_pc),
        .if_ready_o(if_ready), .flush_i(flush), .ex_ready_i(ex_ready), .id_valid_o(id_valid),
        .id_pc_o(id_pc), .read_en1_o(read_en1), .read_en2_o(read_en2),
        .read_addr1_o(read_addr1), .read_addr2_o(read_addr2), .reg_write_o(reg_write),
        .reg_addr_o(reg_addr), .mem_read_o(mem_read), .mem_write_o(mem_write), .imm_o(imm),
        .alu_op_o(alu_op), .br_type_o(br_type), .illegal_o(illegal)
    );

    typedef struct packed {
        logic re1, re2; logic [3:0] ra1, ra2; logic we; logic [3:0] wa;
        logic mr, mw; logic [15:0] imm; logic [3:0] alu; logic [2:0] br; logic ill;
    } exp_t;

    int n_assert = 0;
    int n_fail   = 0;

    // Mnemonic table: an opcode matches entry i when (op & masks[i]) == match[i].
    localparam int NMN = 30;
    typedef enum int {
        NOP, B, BEQZ, BNEZ, SLL, SRL, SRA, ADDIU3, ADDIU, BTEQZ, ADDSP, MTSP, LI, MOVE,
        LWSP, LW, SWSP, SW, ADDU, SUBU, AND_, OR_, CMP, SRAV, JR, JALR, MFPC, JRRA, MFIH, MTIH
    } mn_t;
    logic [15:0] masks [NMN] = '{16'hFFFF, 16'hF800, 16'hF800, 16'hF800, 16'hF803, 16'hF803,
        16'hF803, 16'hF810, 16'hF800, 16'hFF00, 16'hFF00, 16'hFF1F, 16'hF800, 16'hF81F,
        16'hF800, 16'hF800, 16'hF800, 16'hF800, 16'hF803, 16'hF803, 16'hF81F, 16'hF81F,
        16'hF81F, 16'hF81F, 16'hF8FF, 16'hF8FF, 16'hF8FF, 16'hFFFF, 16'hF8FF, 16'hF8FF};
    logic [15:0] match [NMN] = '{16'h0800, 16'h1000, 16'h2000, 16'h2800, 16'h3000, 16'h3002,
        16'h3003, 16'h4000, 16'h4800, 16'h6000, 16'h6300, 16'h6400, 16'h6800, 16'h7800,
        16'h9000, 16'h9800, 16'hD000, 16'hD800, 16'hE001, 16'hE003, 16'hE80C, 16'hE80D,
        16'hE80A, 16'hE807, 16'hE800, 16'hE8C0, 16'hE840, 16'hE820, 16'hF000, 16'hF001};

    function automatic int classify(input logic [15:0] op);
        for (int i = 0; i < NMN; i++)
            if ((op & masks[i]) == match[i]) return i;
        return -1;
    endfunction

    function automatic exp_t ref_decode(input logic [15:0] op);
        exp_t e = '0;
        logic [3:0]  rx  = {1'b0, op[10:8]};
        logic [3:0]  ry  = {1'b0, op[7:5]};
        logic [3:0]  rz  = {1'b0, op[4:2]};
        logic [15:0] s8  = {{8{op[7]}}, op[7:0]};
        logic [15:0] s5  = {{11{op[4]}}, op[4:0]};
        logic [15:0] sh  = (op[4:2] == 3'd0) ? 16'd8 : {13'd0, op[4:2]};
        int m = classify(op);
        case (m)
            NOP:    ;
            B:      begin e.imm = {{5{op[10]}}, op[10:0]}; e.br = 3'd1; end
            BEQZ:   begin e.re1 = 1; e.ra1 = rx; e.imm = s8; e.br = 3'd2; end
            BNEZ:   begin e.re1 = 1; e.ra1 = rx; e.imm = s8; e.br = 3'd3; end
            BTEQZ:  begin e.re1 = 1; e.ra1 = 4'd9; e.imm = s8; e.br = 3'd4; end
            SLL, SRL, SRA: begin
                e.re2 = 1; e.ra2 = ry; e.we = 1; e.wa = rx; e.imm = sh;
                e.alu = (m == SLL) ? 4'd4 : (m == SRL) ? 4'd5 : 4'd6;
            end
            ADDIU3: begin e.re1 = 1; e.ra1 = rx; e.we = 1; e.wa = ry; e.imm = {{12{op[3]}}, op[3:0]}; end
            ADDIU:  begin e.re1 = 1; e.ra1 = rx; e.we = 1; e.wa = rx; e.imm = s8; end
            ADDSP:  begin e.re1 = 1; e.ra1 = 4'd8; e.we = 1; e.wa = 4'd8; e.imm = s8; end
            MTSP:   begin e.re1 = 1; e.ra1 = rx; e.we = 1; e.wa = 4'd8; e.alu = 4'd9; end
            LI:     begin e.we = 1; e.wa = rx; e.imm = {8'd0, op[7:0]}; e.alu = 4'd10; end
            MOVE:   begin e.re2 = 1; e.ra2 = ry; e.we = 1; e.wa = rx; e.alu = 4'd10; end
            LWSP:   begin e.re1 = 1; e.ra1 = 4'd8; e.we = 1; e.wa = rx; e.mr = 1; e.imm = s8; end
            LW:     begin e.re1 = 1; e.ra1 = rx; e.we = 1; e.wa = ry; e.mr = 1; e.imm = s5; end
            SWSP:   begin e.re1 = 1; e.ra1 = 4'd8; e.re2 = 1; e.ra2 = rx; e.mw = 1; e.imm = s8; end
            SW:     begin e.re1 = 1; e.ra1 = rx; e.re2 = 1; e.ra2 = ry; e.mw = 1; e.imm = s5; end
            ADDU, SUBU: begin
                e.re1 = 1; e.ra1 = rx; e.re2 = 1; e.ra2 = ry; e.we = 1; e.wa = rz;
                e.alu = (m == SUBU) ? 4'd1 : 4'd0;
            end
            AND_, OR_, CMP, SRAV: begin
                e.re1 = 1; e.ra1 = rx; e.re2 = 1; e.ra2 = ry; e.we = 1;
                e.wa  = (m == CMP) ? 4'd9 : (m == SRAV) ? ry : rx;
                e.alu = (m == AND_) ? 4'd2 : (m == OR_) ? 4'd3 : (m == CMP) ? 4'd8 : 4'd7;
            end
            JR:     begin e.re1 = 1; e.ra1 = rx; e.alu = 4'd9; e.br = 3'd5; end
            JALR:   begin e.re1 = 1; e.ra1 = rx; e.we = 1; e.wa = 4'd11; e.alu = 4'd11; e.br = 3'd5; end
            MFPC:   begin e.we = 1; e.wa = rx; e.alu = 4'd11; end
            JRRA:   begin e.re1 = 1; e.ra1 = 4'd11; e.alu = 4'd9; e.br = 3'd5; end
            MFIH:   begin e.re1 = 1; e.ra1 = 4'd10; e.we = 1; e.wa = rx; e.alu = 4'd9; end
            MTIH:   begin e.re1 = 1; e.ra1 = rx; e.we = 1; e.wa = 4'd10; e.alu = 4'd9; end
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    // Behavioural model of the held slot.
    logic        m_valid = 1'b0;
    logic        m_zero  = 1'b0;
    exp_t        m_rec   = '0;
    logic [15:0] m_pc    = '0;

    function automatic logic model_ready();
        exp_t d = ref_decode(if_op);
        logic uses = (d.re1 && d.ra1 == m_rec.wa) || (d.re2 && d.ra2 == m_rec.wa);
        return !(m_valid && m_rec.mr && m_rec.we && uses) && (!m_valid || ex_ready);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        if (!flush) chk("if_ready", 32'(if_ready), 32'(model_ready()));
        chk("id_valid", 32'(id_valid), 32'(m_valid));
        if (m_valid || m_zero) begin
            chk("id_pc", 32'(id_pc), 32'(m_pc));
            chk("read_en1", 32'(read_en1), 32'(m_rec.re1));
            chk("read_en2", 32'(read_en2), 32'(m_rec.re2));
            if (m_rec.re1 || m_zero) chk("read_addr1", 32'(read_addr1), 32'(m_rec.ra1));
            if (m_rec.re2 || m_zero) chk("read_addr2", 32'(read_addr2), 32'(m_rec.ra2));
            chk("reg_write", 32'(reg_write), 32'(m_rec.we));
            if (m_rec.we || m_zero) chk("reg_addr", 32'(reg_addr), 32'(m_rec.wa));
            chk("mem_read", 32'(mem_read), 32'(m_rec.mr));
            chk("mem_write", 32'(mem_write), 32'(m_rec.mw));
            chk("imm", 32'(imm), 32'(m_rec.imm));
            chk("alu_op", 32'(alu_op), 32'(m_rec.alu));
            chk("br_type", 32'(br_type), 32'(m_rec.br));
            chk("illegal", 32'(illegal), 32'(m_rec.ill));
        end
    endtask

    task automatic update();
        logic rdy = model_ready();
        if (!rst_n) begin
            m_valid = 0; m_zero = 1; m_rec = '0; m_pc = '0;
        end else if (flush) begin
            m_valid = 0;
        end else if (if_valid && rdy) begin
            m_valid = 1; m_zero = 0; m_rec = ref_decode(if_op); m_pc = if_pc;
        end else if (m_valid && ex_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [15:0] op,
                         input logic [15:0] pc, input logic er, input logic fl);
        rst_n = r; if_valid = v; if_op = op; if_pc = pc; ex_ready = er; flush = fl;
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        update();
        #1;
    endtask

    function automatic logic [15:0] rand_op();
        int k = $urandom_range(0, 9);
        int i = $urandom_range(0, NMN - 1);
        if (k < 2) return 16'h9800 | (16'($urandom) & 16'h07FF);
        if (k < 8) return match[i] | (16'($urandom) & ~masks[i]);
        return 16'($urandom);
    endfunction

    initial begin
        drive(0, 0, 16'h0000, 16'h0000, 0, 0);
        @(posedge clk);
        update();
        #1;
        tick();
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_imm", 32'(imm), 32'd0);

        // ADDU R2,R5 -> R1
        drive(1, 1, 16'hE2A5, 16'h0100, 1, 0);
        tick();
        chk("addu_valid", 32'(id_valid), 32'd1);
        chk("addu_ra1", 32'(read_addr1), 32'd2);
        chk("addu_ra2", 32'(read_addr2), 32'd5);
        chk("addu_wa", 32'(reg_addr), 32'd1);
        chk("addu_alu", 32'(alu_op), 32'd0);

        // LW R1 then ADDU using R1: one stall, one bubble
        drive(1, 1, 16'h9A20, 16'h0102, 1, 0);
        tick();
        drive(1, 1, 16'hE12D, 16'h0104, 1, 0);
        #1;
        chk("hz_if_ready", 32'(if_ready), 32'd0);
        tick();
        chk("hz_bubble", 32'(id_valid), 32'd0);
        tick();
        chk("hz_issue_valid", 32'(id_valid), 32'd1);
        chk("hz_issue_pc", 32'(id_pc), 32'h0104);

        drive(1, 1, 16'h49FF, 16'h0106, 1, 0); tick();
        chk("addiu_imm", 32'(imm), 32'hFFFF);
        drive(1, 1, 16'h69FF, 16'h0108, 1, 0); tick();
        chk("li_imm", 32'(imm), 32'h00FF);
        drive(1, 1, 16'h3040, 16'h010A, 1, 0); tick();
        chk("sll_imm", 32'(imm), 32'd8);

        // Stall for three cycles with a new opcode waiting
        drive(1, 1, 16'hE2A5, 16'h0200, 1, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 16'hE12D, 16'h0202, 0, 0);
            #1;
            chk("stall_if_ready", 32'(if_ready), 32'd0);
            tick();
            chk("stall_pc", 32'(id_pc), 32'h0200);
        end
        drive(1, 1, 16'hE12D, 16'h0202, 1, 0); tick();
        chk("resume_pc", 32'(id_pc), 32'h0202);
        drive(1, 0, 16'h0800, 16'h0000, 1, 0); tick();
        chk("no_dup_valid", 32'(id_valid), 32'd0);

        // Flush drops both held and incoming
        drive(1, 1, 16'hE2A5, 16'h0300, 1, 0); tick();
        drive(1, 1, 16'h49FF, 16'h7777, 0, 1); tick();
        chk("flush_valid", 32'(id_valid), 32'd0);
        drive(1, 0, 16'h0800, 16'h0000, 1, 0); tick(); tick();
        chk("flush_dropped", 32'(id_valid), 32'd0);

        drive(1, 1, 16'hD305, 16'h0400, 1, 0); tick();
        chk("swsp_ra1", 32'(read_addr1), 32'd8);
        chk("swsp_ra2", 32'(read_addr2), 32'd3);
        chk("swsp_mw", 32'(mem_write), 32'd1);
        chk("swsp_imm", 32'(imm), 32'd5);
        drive(1, 1, 16'hF800, 16'h0402, 1, 0); tick();
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_enables", 32'({read_en1, read_en2, reg_write, mem_read, mem_write}), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 99) != 0, $urandom_range(0, 4) != 0, rand_op(),
                  16'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0);
            tick();
        end
        drive(1, 0, 16'h0800, 16'h0000, 1, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
